// File: rtl/requant_act_multi.sv
// Multi-lane requantizer: per-channel bias, fixed-point multiply, round-half-up shift,
// optional ReLU and saturation, in a 3-stage valid/ready pipeline.

module requant_lane #(
  parameter int IN_W   = 32,
  parameter int BIAS_W = 32,
  parameter int MULT_W = 16,
  parameter int SH_W   = 5,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_mode,
  input  logic [IN_W-1:0]   i_acc,
  input  logic [BIAS_W-1:0] i_bias,
  input  logic [MULT_W-1:0] i_mult,
  input  logic [SH_W-1:0]   i_shift,
  output logic [OUT_W-1:0]  o_data
);
  localparam int SW = IN_W + 1;
  localparam int PW = SW + MULT_W;
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] MAXV = RW'((1 << (OUT_W-1)) - 1);
  localparam logic signed [RW-1:0] MINV = ~MAXV;

  logic signed [SW-1:0] r_sum;
  logic signed [PW-1:0] r_prod;
  logic signed [SW-1:0] w_sum;
  logic signed [PW-1:0] w_prod;
  logic signed [RW-1:0] w_rnd, w_r, w_lo;
  logic [OUT_W-1:0]     w_clamp;

  assign w_sum  = SW'($signed(i_acc)) + SW'($signed(i_bias));
  assign w_prod = PW'(r_sum) * PW'($signed(i_mult));

  // One extra bit of headroom keeps the rounding add from ever wrapping.
  always_comb begin
    w_rnd = '0;
    if (i_shift != '0) w_rnd = RW'(1) << (i_shift - SH_W'(1));
    w_r  = (RW'(r_prod) + w_rnd) >>> i_shift;
    w_lo = i_mode ? '0 : MINV;
    if (w_r > MAXV)      w_clamp = MAXV[OUT_W-1:0];
    else if (w_r < w_lo) w_clamp = w_lo[OUT_W-1:0];
    else                 w_clamp = w_r[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_prod <= '0;
      o_data <= '0;
    end else if (i_en) begin
      r_sum  <= w_sum;
      r_prod <= w_prod;
      o_data <= w_clamp;
    end
  end
endmodule

module requant_act_multi #(
  parameter int LANES  = 4,
  parameter int IN_W   = 32,
  parameter int BIAS_W = 32,
  parameter int MULT_W = 16,
  parameter int SH_W   = 5,
  parameter int OUT_W  = 8,
  parameter int NUM_CH = 64,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_mode,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_addr,
  input  logic [BIAS_W-1:0]      cfg_bias,
  input  logic [MULT_W-1:0]      cfg_mult,
  input  logic [SH_W-1:0]        cfg_shift,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_first,
  input  logic [LANES*IN_W-1:0]  i_acc,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [CH_W-1:0]        o_ch,
  output logic [LANES*OUT_W-1:0] o_data
);
  localparam int STAGES = 3;

  logic [BIAS_W-1:0] r_bias  [NUM_CH];
  logic [MULT_W-1:0] r_mult  [NUM_CH];
  logic [SH_W-1:0]   r_shift [NUM_CH];

  logic [STAGES-1:0] r_vld_pipe;
  logic [CH_W-1:0]   r_ch_cnt, r_ch_s1, r_ch_s2;
  logic [MULT_W-1:0] r_mult_s1;
  logic [SH_W-1:0]   r_shift_s1, r_shift_s2;
  logic              w_en;
  logic [CH_W-1:0]   w_ch;
  logic [BIAS_W-1:0] w_bias;

  assign w_en    = ~o_valid | o_ready;
  assign i_ready = w_en;
  assign o_valid = r_vld_pipe[STAGES-1];
  assign w_ch    = i_first ? '0 : r_ch_cnt;
  assign w_bias  = r_bias[w_ch];

  // The S1 capture reads the table before this cycle's cfg write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_bias[i]  <= '0;
        r_mult[i]  <= MULT_W'(1);
        r_shift[i] <= '0;
      end
    end else if (cfg_we) begin
      r_bias[cfg_addr]  <= cfg_bias;
      r_mult[cfg_addr]  <= cfg_mult;
      r_shift[cfg_addr] <= cfg_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_ch_cnt   <= '0;
      r_ch_s1    <= '0;
      r_ch_s2    <= '0;
      o_ch       <= '0;
      r_mult_s1  <= '0;
      r_shift_s1 <= '0;
      r_shift_s2 <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-2:0], i_valid};
      if (i_valid)
        r_ch_cnt <= (w_ch == CH_W'(NUM_CH-1)) ? '0 : w_ch + CH_W'(1);
      r_ch_s1    <= w_ch;
      r_mult_s1  <= r_mult[w_ch];
      r_shift_s1 <= r_shift[w_ch];
      r_ch_s2    <= r_ch_s1;
      r_shift_s2 <= r_shift_s1;
      o_ch       <= r_ch_s2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    requant_lane #(
      .IN_W(IN_W), .BIAS_W(BIAS_W), .MULT_W(MULT_W), .SH_W(SH_W), .OUT_W(OUT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_mode (i_mode),
      .i_acc  (i_acc[k*IN_W +: IN_W]),
      .i_bias (w_bias),
      .i_mult (r_mult_s1),
      .i_shift(r_shift_s2),
      .o_data (o_data[k*OUT_W +: OUT_W])
    );
  end
endmodule

// File: tb/tb_requant_act_multi.sv
// Directed + randomized bench for requant_act_multi with a scoreboard built on integer arithmetic.

module tb_requant_act_multi;
  localparam int LANES = 4, IN_W = 32, BIAS_W = 32, MULT_W = 16, SH_W = 5, OUT_W = 8;
  localparam int NUM_CH = 4, CH_W = 2;

  logic clk = 1'b0;
  logic rst_n, i_mode, cfg_we, i_valid, i_ready, i_first, o_valid, o_ready;
  logic [CH_W-1:0]        cfg_addr, o_ch;
  logic [BIAS_W-1:0]      cfg_bias;
  logic [MULT_W-1:0]      cfg_mult;
  logic [SH_W-1:0]        cfg_shift;
  logic [LANES*IN_W-1:0]  i_acc;
  logic [LANES*OUT_W-1:0] o_data;

  requant_act_multi #(.LANES(LANES), .IN_W(IN_W), .BIAS_W(BIAS_W), .MULT_W(MULT_W),
                      .SH_W(SH_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .i_valid(i_valid),
    .i_ready(i_ready), .i_first(i_first), .i_acc(i_acc), .o_valid(o_valid),
    .o_ready(o_ready), .o_ch(o_ch), .o_data(o_data));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  typedef struct { logic [LANES*OUT_W-1:0] data; logic [CH_W-1:0] ch; } exp_t;
  exp_t q[$];
  exp_t e;
  logic [CH_W-1:0]        obs_ch[$];
  logic [LANES*OUT_W-1:0] obs_data[$];

  longint m_bias[NUM_CH], m_mult[NUM_CH];
  int     m_shift[NUM_CH];
  int     m_cnt, sb_ch;

  // Reference: ((acc+bias)*mult)/2^shift rounded half toward +inf, then clamped.
  function automatic logic [OUT_W-1:0] ref_lane(longint acc, longint b, longint m, int s, bit relu);
    longint v, hi, lo;
    logic [63:0] bits;
    v = (acc + b) * m;
    if (s > 0) v = (v + (longint'(1) <<< (s-1))) >>> s;
    hi = (longint'(1) <<< (OUT_W-1)) - 1;
    lo = relu ? 0 : -hi - 1;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    bits = v;
    return bits[OUT_W-1:0];
  endfunction

  function automatic logic [LANES*IN_W-1:0] pack_acc(int a0, int a1, int a2, int a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [LANES*OUT_W-1:0] pack_out(int d0, int d1, int d2, int d3);
    return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endfunction

  // Scoreboard capture: expected value is fixed at acceptance using the table as it was before this edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_bias[i] = 0; m_mult[i] = 1; m_shift[i] = 0; end
    end else begin
      if (i_valid && i_ready) begin
        sb_ch = i_first ? 0 : m_cnt;
        for (int k = 0; k < LANES; k++)
          e.data[k*OUT_W +: OUT_W] = ref_lane(longint'($signed(i_acc[k*IN_W +: IN_W])),
                                               m_bias[sb_ch], m_mult[sb_ch], m_shift[sb_ch], i_mode);
        e.ch = CH_W'(sb_ch);
        q.push_back(e);
        m_cnt = (sb_ch == NUM_CH-1) ? 0 : sb_ch + 1;
      end
      if (cfg_we) begin
        m_bias[cfg_addr]  = longint'($signed(cfg_bias));
        m_mult[cfg_addr]  = longint'($signed(cfg_mult));
        m_shift[cfg_addr] = int'(cfg_shift);
      end
    end
  end

  logic                   prev_stall = 1'b0;
  logic [LANES*OUT_W-1:0] prev_data;
  logic [CH_W-1:0]        prev_ch;
  exp_t                   got;

  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      n_cmp++;
      assert (i_ready === !(o_valid && !o_ready)) else begin
        n_err++; $error("FAIL i_ready: got %b want %b", i_ready, !(o_valid && !o_ready)); end
      if (prev_stall) begin
        n_cmp++;
        assert (o_data === prev_data && o_ch === prev_ch) else begin
          n_err++; $error("FAIL stall_hold: got %h/%0d want %h/%0d", o_data, o_ch, prev_data, prev_ch); end
      end
      if (o_valid && o_ready) begin
        n_cmp++;
        assert (q.size() != 0) else begin
          n_err++; $error("FAIL sb_extra: got beat %h with no expected entry", o_data); end
        if (q.size() != 0) begin
          got = q.pop_front();
          n_cmp++;
          assert (o_data === got.data) else begin
            n_err++; $error("FAIL sb_data: got %h want %h", o_data, got.data); end
          n_cmp++;
          assert (o_ch === got.ch) else begin
            n_err++; $error("FAIL sb_ch: got %0d want %0d", o_ch, got.ch); end
          obs_ch.push_back(o_ch);
          obs_data.push_back(o_data);
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_data  = o_data;
      prev_ch    = o_ch;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input logic [63:0] got_v, input logic [63:0] want, input string tag);
    n_cmp++;
    assert (got_v === want) else begin
      n_err++; $error("FAIL %s: got %h want %h", tag, got_v, want); end
  endtask

  task automatic cfg(input int addr, input int b, input int m, input int s);
    cfg_we = 1'b1; cfg_addr = CH_W'(addr); cfg_bias = BIAS_W'(b);
    cfg_mult = MULT_W'(m); cfg_shift = SH_W'(s);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [LANES*IN_W-1:0] acc, input logic first);
    int t;
    i_valid = 1'b1; i_acc = acc; i_first = first;
    t = 0;
    while (!i_ready && t < 50) begin tick(); t++; end
    check(64'(t < 50), 64'(1), "send_timeout");
    tick();
    i_valid = 1'b0; i_first = 1'b0;
  endtask

  task automatic expect_out(input logic [LANES*OUT_W-1:0] want, input int wch, input string tag);
    int t;
    t = 0;
    while (!o_valid && t < 20) begin tick(); t++; end
    check(64'(o_valid), 64'(1), {tag, "_valid"});
    check(64'(o_data), 64'(want), {tag, "_data"});
    check(64'(o_ch), 64'(wch), {tag, "_ch"});
    tick();
  endtask

  // Streams n beats; i_first on beat 0 and on beat first2; optional cfg race and random o_ready.
  task automatic stream(input int n, input int first2, input int race_idx, input bit bp);
    int t;
    for (int b = 0; b < n; b++) begin
      i_valid = 1'b1;
      i_first = (b == 0) || (b == first2);
      for (int k = 0; k < LANES; k++)
        i_acc[k*IN_W +: IN_W] = (race_idx >= 0) ? IN_W'((k + 1) * 10) :
                                (b % 3 == 0) ? $urandom : $urandom_range(0, 4000) - 2000;
      if (b == race_idx) begin
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_bias = 50; cfg_mult = 1; cfg_shift = 0;
      end
      t = 0;
      while (!i_ready && t < 100) begin
        tick();
        if (bp) begin o_ready = 1'($urandom_range(0, 1)); #1; end
        t++;
      end
      check(64'(t < 100), 64'(1), "stream_timeout");
      tick();
      cfg_we = 1'b0;
      if (bp) begin o_ready = 1'($urandom_range(0, 1)); #1; end
    end
    i_valid = 1'b0; i_first = 1'b0; o_ready = 1'b1;
    repeat (8) tick();
  endtask

  int exp_ch_a[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
  int exp_ch_b[9] = '{0, 1, 2, 3, 0, 1, 0, 1, 2};

  initial begin
    rst_n = 1'b0; i_mode = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_bias = '0; cfg_mult = '0;
    cfg_shift = '0; i_valid = 1'b0; i_first = 1'b0; i_acc = '0; o_ready = 1'b1;
    tick(); tick();
    check(64'(o_valid), 0, "rst_o_valid");
    check(64'(o_data), 0, "rst_o_data");
    check(64'(o_ch), 0, "rst_o_ch");
    rst_n = 1'b1;
    tick();

    // Identity table with exact 3-edge latency
    i_valid = 1'b1; i_first = 1'b1; i_acc = pack_acc(5, -3, 127, -200);
    tick();
    i_valid = 1'b0; i_first = 1'b0;
    check(64'(o_valid), 0, "lat_edge1");
    tick();
    check(64'(o_valid), 0, "lat_edge2");
    tick();
    check(64'(o_valid), 1, "lat_edge3");
    check(64'(o_data), 64'(pack_out(5, -3, 127, -128)), "ident_data");
    check(64'(o_ch), 0, "ident_ch");
    tick();

    // Round half toward +inf
    cfg(0, 0, 1, 2);
    send(pack_acc(6, 5, -6, -7), 1'b1);
    expect_out(pack_out(2, 1, -1, -2), 0, "round");

    // ReLU with bias and scale on channel 1
    cfg(1, 100, 3, 4);
    i_mode = 1'b1;
    send(pack_acc(0, 0, 0, 0), 1'b1);
    expect_out(pack_out(0, 0, 0, 0), 0, "relu_ch0");
    send(pack_acc(-200, 1000, 0, -100), 1'b0);
    expect_out(pack_out(0, 127, 19, 0), 1, "relu_ch1");
    repeat (4) tick();
    i_mode = 1'b0;

    // Channel wrap, then a mid-stream i_first
    obs_ch.delete(); obs_data.delete();
    stream(9, -1, -1, 1'b0);
    check(64'(obs_ch.size()), 9, "wrap_count");
    for (int i = 0; i < 9 && i < obs_ch.size(); i++) check(64'(obs_ch[i]), 64'(exp_ch_a[i]), "wrap_ch");
    obs_ch.delete(); obs_data.delete();
    stream(9, 6, -1, 1'b0);
    check(64'(obs_ch.size()), 9, "first6_count");
    for (int i = 0; i < 9 && i < obs_ch.size(); i++) check(64'(obs_ch[i]), 64'(exp_ch_b[i]), "first6_ch");

    // Backpressure with random o_ready
    obs_ch.delete(); obs_data.delete();
    stream(20, -1, -1, 1'b1);
    check(64'(obs_ch.size()), 20, "bp_count");

    // Same-cycle cfg write on ch2 is invisible to that beat, visible to the next ch2 beat
    obs_ch.delete(); obs_data.delete();
    stream(7, -1, 2, 1'b0);
    check(64'(obs_data.size()), 7, "race_count");
    if (obs_data.size() == 7) begin
      check(64'(obs_data[2]), 64'(pack_out(10, 20, 30, 40)), "race_old_bias");
      check(64'(obs_data[6]), 64'(pack_out(60, 70, 80, 90)), "race_new_bias");
    end

    // Reset mid-stream
    i_valid = 1'b1; i_first = 1'b1; i_acc = pack_acc(1, 2, 3, 4);
    tick();
    i_first = 1'b0;
    tick();
    tick();
    rst_n = 1'b0; i_valid = 1'b0;
    #1;
    check(64'(o_valid), 0, "midrst_async");
    tick();
    check(64'(o_valid), 0, "midrst_edge");
    rst_n = 1'b1;
    tick();
    send(pack_acc(6, 5, -6, -7), 1'b1);
    expect_out(pack_out(6, 5, -6, -7), 0, "post_rst_identity");
    repeat (6) tick();

    check(64'(q.size()), 0, "sb_drained");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
